// File: rtl/mmio_timer_pkg.sv
// Shared register offsets, CTRL bit positions and FSM state encoding for the
// memory-mapped timer.
package mmio_timer_pkg;

  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_COMPARE  = 5'h04;
  localparam logic [4:0] OFF_COUNT    = 5'h08;
  localparam logic [4:0] OFF_STATUS   = 5'h0C;
  localparam logic [4:0] OFF_PRESCALE = 5'h10;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_PER = 1;
  localparam int unsigned CTRL_IE  = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EXPIRED
  } timer_state_t;

endpackage

// File: rtl/mmio_timer_tick_gen.sv
// Prescaler: counts core-clock cycles while enabled and emits a one-cycle
// tick when the count reaches the programmed prescale value.
module tick_gen #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] prescale,
  output logic             tick
);

  logic [WIDTH-1:0] pc;

  assign tick = en && (pc == prescale);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pc <= '0;
    end else if (en) begin
      pc <= tick ? '0 : pc + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer: register file, address decode/read mux, run-state FSM
// and the compare counter driven by the prescaler tick.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h0000_00A0,
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic        irq
);

  timer_state_t     state, state_next;
  logic [2:0]       ctrl;
  logic [WIDTH-1:0] compare, count, prescale;
  logic             done;
  logic             tick, match, restart;

  logic [31:0] off;
  logic [4:0]  sel;
  logic        unused_off;
  logic        ctrl_wr, compare_wr, status_wr, prescale_wr;

  // An address below BASE wraps to a huge offset, so one bound covers both ends.
  assign off        = a - BASE;
  assign hit        = (off[31:2] <= 30'd4);
  assign sel        = {off[4:2], 2'b00};
  assign unused_off = &{1'b0, off[1:0]};

  assign ctrl_wr     = we && hit && (sel == OFF_CTRL);
  assign compare_wr  = we && hit && (sel == OFF_COMPARE);
  assign status_wr   = we && hit && (sel == OFF_STATUS);
  assign prescale_wr = we && hit && (sel == OFF_PRESCALE);

  assign match = tick && (count == compare);
  assign irq   = done && ctrl[CTRL_IE];

  tick_gen #(.WIDTH(WIDTH)) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (state == RUN),
    .clr      (restart),
    .prescale (prescale),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A CTRL write always decides the next state, overriding a same-cycle match.
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    unique case (state)
      IDLE: begin
        if (ctrl_wr && wd[CTRL_EN]) begin
          state_next = RUN;
          restart    = 1'b1;
        end
      end
      RUN: begin
        if (ctrl_wr) begin
          state_next = wd[CTRL_EN] ? RUN : IDLE;
          restart    = wd[CTRL_EN];
        end else if (match && !ctrl[CTRL_PER]) begin
          state_next = EXPIRED;
        end
      end
      EXPIRED: begin
        if (ctrl_wr) begin
          state_next = wd[CTRL_EN] ? RUN : IDLE;
          restart    = wd[CTRL_EN];
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      compare  <= '0;
      prescale <= '0;
      count    <= '0;
      done     <= 1'b0;
    end else begin
      if (ctrl_wr)                           ctrl <= wd[2:0];
      else if (match && !ctrl[CTRL_PER])     ctrl[CTRL_EN] <= 1'b0;

      if (compare_wr)  compare  <= WIDTH'(wd);
      if (prescale_wr) prescale <= WIDTH'(wd);

      if (restart) begin
        count <= '0;
      end else if ((state == RUN) && !ctrl_wr && tick) begin
        if (!match)                count <= count + WIDTH'(1);
        else if (ctrl[CTRL_PER])   count <= '0;
      end

      if (match)                    done <= 1'b1;
      else if (status_wr && wd[0])  done <= 1'b0;
    end
  end

  always_comb begin
    rd = '0;
    if (hit) begin
      case (sel)
        OFF_CTRL:     rd = {29'b0, ctrl};
        OFF_COMPARE:  rd = 32'(compare);
        OFF_COUNT:    rd = 32'(count);
        OFF_STATUS:   rd = {31'b0, done};
        OFF_PRESCALE: rd = 32'(prescale);
        default:      rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: expected values go into a scoreboard queue as
// stimulus is driven and are popped when the DUT's bus response is sampled.
module tb_mmio_timer;

  localparam logic [31:0] BASE   = 32'h0000_00A0;
  localparam logic [31:0] A_CTRL = BASE + 32'd0;
  localparam logic [31:0] A_CMP  = BASE + 32'd4;
  localparam logic [31:0] A_CNT  = BASE + 32'd8;
  localparam logic [31:0] A_STAT = BASE + 32'd12;
  localparam logic [31:0] A_PRE  = BASE + 32'd16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        hit;
  logic        irq;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [31:0] sb[$];

  mmio_timer #(.BASE(BASE), .WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .hit   (hit),
    .irq   (irq)
  );

  always #50 clk = ~clk;

  task automatic expect_val(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s: observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic wait_edges(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1;
    a  = addr;
    wd = data;
    @(posedge clk);
    #1;
    we = 1'b0;
    wd = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    expect_val(exp);
    a = addr;
    #1;
    chk(tag, rd);
  endtask

  task automatic hit_chk(input string tag, input logic [31:0] addr, input logic exp);
    expect_val({31'b0, exp});
    a = addr;
    #1;
    chk(tag, {31'b0, hit});
  endtask

  task automatic irq_chk(input string tag, input logic exp);
    expect_val({31'b0, exp});
    #1;
    chk(tag, {31'b0, irq});
  endtask

  initial begin
    wait_edges(2);
    reset = 1'b0;

    // Reset state and window boundaries
    rd_chk("rst_ctrl", A_CTRL, 32'd0);
    rd_chk("rst_cmp",  A_CMP,  32'd0);
    rd_chk("rst_cnt",  A_CNT,  32'd0);
    rd_chk("rst_stat", A_STAT, 32'd0);
    rd_chk("rst_pre",  A_PRE,  32'd0);
    irq_chk("rst_irq", 1'b0);
    wait_edges(1);
    hit_chk("hit_base",  BASE,          1'b1);
    hit_chk("hit_top",   BASE + 32'd16, 1'b1);
    hit_chk("hit_above", BASE + 32'd20, 1'b0);
    hit_chk("hit_below", BASE - 32'd4,  1'b0);
    hit_chk("hit_far",   32'h0000_0200, 1'b0);
    rd_chk("rd_outside", 32'h0000_0200, 32'd0);

    // One-shot: PRESCALE=0, COMPARE=3, CTRL=EN|IE -> DONE at edge 4
    bus_write(A_CMP, 32'd3);
    rd_chk("cmp_rb", A_CMP, 32'd3);
    rd_chk("cmp_rb_unaligned", A_CMP + 32'd2, 32'd3);
    bus_write(A_CTRL, 32'd5);
    wait_edges(3);
    rd_chk("os_stat_e3", A_STAT, 32'd0);
    irq_chk("os_irq_e3", 1'b0);
    wait_edges(1);
    rd_chk("os_stat_e4", A_STAT, 32'd1);
    irq_chk("os_irq_e4", 1'b1);
    rd_chk("os_cnt_e4",  A_CNT,  32'd3);
    rd_chk("os_ctrl_e4", A_CTRL, 32'd4);
    wait_edges(3);
    rd_chk("os_cnt_hold", A_CNT, 32'd3);
    bus_write(A_STAT, 32'd0);
    rd_chk("w0_no_clear", A_STAT, 32'd1);
    bus_write(A_STAT, 32'd1);
    rd_chk("w1c_stat", A_STAT, 32'd0);
    irq_chk("w1c_irq", 1'b0);

    // Periodic: PRESCALE=1, COMPARE=2 -> DONE at edge 6, again at edge 12
    bus_write(A_PRE, 32'd1);
    bus_write(A_CMP, 32'd2);
    bus_write(A_CTRL, 32'd3);
    wait_edges(5);
    rd_chk("per_stat_e5", A_STAT, 32'd0);
    wait_edges(1);
    rd_chk("per_stat_e6", A_STAT, 32'd1);
    rd_chk("per_cnt_e6",  A_CNT,  32'd0);
    irq_chk("per_irq_noie", 1'b0);
    wait_edges(1);
    bus_write(A_STAT, 32'd1);
    rd_chk("per_stat_e8", A_STAT, 32'd0);
    wait_edges(3);
    rd_chk("per_stat_e11", A_STAT, 32'd0);
    wait_edges(1);
    rd_chk("per_stat_e12", A_STAT, 32'd1);
    rd_chk("per_cnt_e12",  A_CNT,  32'd0);

    // W1C on the match edge (edge 18): set wins
    wait_edges(5);
    bus_write(A_STAT, 32'd1);
    rd_chk("w1c_vs_match", A_STAT, 32'd1);
    rd_chk("cnt_match18",  A_CNT,  32'd0);

    // Stop mid-count at COUNT=5, COUNT writes ignored, restart from 0
    bus_write(A_CTRL, 32'd0);
    bus_write(A_PRE, 32'd0);
    bus_write(A_CMP, 32'd100);
    bus_write(A_CTRL, 32'd1);
    wait_edges(5);
    bus_write(A_CTRL, 32'd0);
    rd_chk("stop_cnt", A_CNT, 32'd5);
    wait_edges(3);
    rd_chk("stop_cnt_hold", A_CNT, 32'd5);
    bus_write(A_CNT, 32'd77);
    rd_chk("cnt_ro", A_CNT, 32'd5);
    bus_write(A_CTRL, 32'd1);
    rd_chk("restart_cnt0", A_CNT, 32'd0);
    wait_edges(2);
    rd_chk("restart_cnt2", A_CNT, 32'd2);

    // One-cycle reset mid-run (DONE still set from above)
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_chk("mr_ctrl", A_CTRL, 32'd0);
    rd_chk("mr_cmp",  A_CMP,  32'd0);
    rd_chk("mr_cnt",  A_CNT,  32'd0);
    rd_chk("mr_stat", A_STAT, 32'd0);
    rd_chk("mr_pre",  A_PRE,  32'd0);
    irq_chk("mr_irq", 1'b0);
    wait_edges(3);
    rd_chk("mr_idle_cnt", A_CNT, 32'd0);

    // COMPARE=0 matches on the first tick
    bus_write(A_CTRL, 32'd5);
    wait_edges(1);
    rd_chk("c0_stat", A_STAT, 32'd1);
    irq_chk("c0_irq", 1'b1);
    rd_chk("c0_cnt",  A_CNT,  32'd0);
    rd_chk("c0_ctrl", A_CTRL, 32'd4);

    // Match and CTRL EN=0 write on the same edge: CTRL wins, DONE still sets
    bus_write(A_STAT, 32'd1);
    bus_write(A_CMP, 32'd2);
    bus_write(A_CTRL, 32'd3);
    wait_edges(2);
    bus_write(A_CTRL, 32'd0);
    rd_chk("mc_stat", A_STAT, 32'd1);
    rd_chk("mc_ctrl", A_CTRL, 32'd0);
    rd_chk("mc_cnt",  A_CNT,  32'd2);
    wait_edges(2);
    rd_chk("mc_cnt_idle", A_CNT, 32'd2);

    if (sb.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_drain: observed=%0d leftover expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=still running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
